// File: rtl/instr_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into words,
// writes them from byte address 0 upward, and holds the processor in reset until done.
module instr_loader #(
  parameter int IWIDTH      = 32,
  parameter int AWIDTH_MEM  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int CWIDTH      = 16
) (
  input  logic                  il_clk,
  input  logic                  il_rst,
  input  logic                  il_i_start,
  input  logic [CWIDTH-1:0]     il_i_count,
  input  logic                  il_i_byte_valid,
  input  logic [7:0]            il_i_byte,
  output logic                  il_o_byte_ready,
  output logic                  il_o_mem_we,
  output logic [AWIDTH_MEM-1:0] il_o_mem_addr,
  output logic [IWIDTH-1:0]     il_o_mem_wdata,
  output logic                  il_o_cpu_rst,
  output logic                  il_o_cpu_ce,
  output logic                  il_o_done,
  output logic                  il_o_err
);

  localparam int NBYTES = IWIDTH / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CWIDTH:0]   DEPTH_LIM = (CWIDTH + 1)'(DEPTH_WORDS);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_e;

  state_e                  state_q;
  logic [CWIDTH-1:0]       count_q;
  logic [CWIDTH-1:0]       word_idx_q;
  logic [BIDX_W-1:0]       byte_idx_q;
  logic [IWIDTH-1:0]       asm_q;
  logic [IWIDTH-1:0]       asm_d;
  logic                    byte_ready_q;
  logic                    mem_we_q;
  logic [AWIDTH_MEM-1:0]   mem_addr_q;
  logic [IWIDTH-1:0]       mem_wdata_q;
  logic                    cpu_rst_q;
  logic                    cpu_ce_q;
  logic                    done_q;
  logic                    err_q;
  logic                    start_ok;
  logic                    byte_fire;

  // Assembly register with the incoming byte merged in, so the final byte of
  // a word can go straight to the write-data register.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_idx_q, 3'b000} +: 8] = il_i_byte;
  end

  assign start_ok  = (il_i_count != '0) && ({1'b0, il_i_count} <= DEPTH_LIM);
  assign byte_fire = il_i_byte_valid && byte_ready_q;

  // NOTE: every register here is updated with <= so all next-state decisions
  // see the values from before this edge, regardless of statement order.
  always_ff @(posedge il_clk) begin
    if (il_rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      cpu_ce_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (il_i_start) begin
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            cpu_ce_q  <= 1'b0;
            if (start_ok) begin
              state_q      <= RECV;
              count_q      <= il_i_count;
              word_idx_q   <= '0;
              byte_idx_q   <= '0;
              byte_ready_q <= 1'b1;
              err_q        <= 1'b0;
            end else begin
              state_q      <= ERR;
              byte_ready_q <= 1'b0;
              err_q        <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_fire) begin
            asm_q <= asm_d;
            if (byte_idx_q == LAST_BYTE) begin
              state_q      <= WRITE;
              byte_idx_q   <= '0;
              byte_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= AWIDTH_MEM'(word_idx_q) << 2;
              mem_wdata_q  <= asm_d;
            end else begin
              byte_idx_q <= byte_idx_q + BIDX_W'(1);
            end
          end
        end
        WRITE: begin
          mem_we_q <= 1'b0;
          if (word_idx_q == count_q - CWIDTH'(1)) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b0;
            cpu_ce_q  <= 1'b1;
          end else begin
            state_q      <= RECV;
            word_idx_q   <= word_idx_q + CWIDTH'(1);
            byte_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign il_o_byte_ready = byte_ready_q;
  assign il_o_mem_we     = mem_we_q;
  assign il_o_mem_addr   = mem_addr_q;
  assign il_o_mem_wdata  = mem_wdata_q;
  assign il_o_cpu_rst    = cpu_rst_q;
  assign il_o_cpu_ce     = cpu_ce_q;
  assign il_o_done       = done_q;
  assign il_o_err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued as bytes are
// scheduled and matched against every observed memory write strobe.
module tb_instr_loader;

  localparam int IW = 32;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic          valid = 1'b0;
  logic [7:0]    bdata = '0;
  logic          byte_ready, mem_we, cpu_rst, cpu_ce, done, err;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;

  instr_loader #(.IWIDTH(IW), .AWIDTH_MEM(AW), .DEPTH_WORDS(DW), .CWIDTH(CW)) dut (
    .il_clk(clk), .il_rst(rst), .il_i_start(start), .il_i_count(count),
    .il_i_byte_valid(valid), .il_i_byte(bdata), .il_o_byte_ready(byte_ready),
    .il_o_mem_we(mem_we), .il_o_mem_addr(mem_addr), .il_o_mem_wdata(mem_wdata),
    .il_o_cpu_rst(cpu_rst), .il_o_cpu_ce(cpu_ce), .il_o_done(done), .il_o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] tx_q[$];
  wr_t        mon_exp;
  int vectors = 0, miscompares = 0, cyc = 0, nwrites = 0, last_we_cyc = -10;

  always @(posedge clk) cyc++;

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      nwrites++;
      last_we_cyc = cyc;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if (mem_addr !== mon_exp.addr || mem_wdata !== mon_exp.data) begin
          miscompares++;
          $display("FAIL write_match: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_exp.addr, mon_exp.data);
        end
      end
      vectors++;
      if (byte_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_write: got byte_ready=%b, required 0", byte_ready);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] c);
    start = 1'b1;
    count = c;
    tick();
    start = 1'b0;
    count = CW'($urandom);
  endtask

  task automatic queue_word(input logic [31:0] w, input int idx);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    sb.push_back({AW'(idx * 4), w});
  endtask

  task automatic send_bytes(input int n, input bit toggle);
    for (int k = 0; k < n && tx_q.size() > 0; k++) begin
      int   waited;
      logic rdy;
      valid  = 1'b1;
      bdata  = tx_q.pop_front();
      waited = 0;
      do begin
        @(negedge clk);
        rdy = byte_ready;
        @(posedge clk);
        #1;
        waited++;
      end while (rdy !== 1'b1 && waited < 50);
      if (rdy !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL byte_ready_timeout: got byte_ready=%b after %0d cycles, required 1", rdy, waited);
        valid = 1'b0;
        return;
      end
      if (toggle) begin
        valid = 1'b0;
        tick();
      end
    end
    valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_timeout: got done=%b, required 1", name, done);
    end else begin
      vectors++;
      if (cyc != last_we_cyc + 1) begin
        miscompares++;
        $display("FAIL %s_done_latency: got done at cycle %0d, required %0d", name, cyc, last_we_cyc + 1);
      end
      vectors++;
      if ({cpu_rst, cpu_ce, err, byte_ready} !== 4'b0100) begin
        miscompares++;
        $display("FAIL %s_done_outputs: got rst/ce/err/rdy=%b%b%b%b, required 0100",
                 name, cpu_rst, cpu_ce, err, byte_ready);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_writes: got %0d outstanding, required 0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({byte_ready, mem_we, cpu_rst, cpu_ce, done, err} !== 6'b001000 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL %s: got rdy/we/rst/ce/done/err=%b%b%b%b%b%b addr=%h data=%h, required 001000 addr=0 data=0",
               name, byte_ready, mem_we, cpu_rst, cpu_ce, done, err, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset_values");
    rst   = 1'b0;
    valid = 1'b1;
    tick();
    tick();
    check_reset_outputs("idle_holds");
    valid = 1'b0;
  endtask

  task automatic test_basic(input bit toggle, input string name);
    do_start(2);
    queue_word(32'h2000_0013, 0);
    queue_word(32'h1122_3344, 1);
    send_bytes(8, toggle);
    wait_done(name);
  endtask

  task automatic test_errors();
    int w0 = nwrites;
    do_start(0);
    vectors++;
    if ({err, cpu_rst, cpu_ce, done, byte_ready} !== 5'b11000) begin
      miscompares++;
      $display("FAIL err_count0: got err/rst/ce/done/rdy=%b%b%b%b%b, required 11000",
               err, cpu_rst, cpu_ce, done, byte_ready);
    end
    repeat (3) tick();
    do_start(CW'(DW + 1));
    vectors++;
    if ({err, cpu_rst, cpu_ce, done, byte_ready} !== 5'b11000) begin
      miscompares++;
      $display("FAIL err_count_over: got err/rst/ce/done/rdy=%b%b%b%b%b, required 11000",
               err, cpu_rst, cpu_ce, done, byte_ready);
    end
    repeat (3) tick();
    vectors++;
    if (nwrites != w0) begin
      miscompares++;
      $display("FAIL err_no_write: got %0d writes, required 0", nwrites - w0);
    end
    do_start(1);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got err=%b, required 0", err);
    end
    queue_word(32'hDEAD_BEEF, 0);
    send_bytes(4, 1'b0);
    wait_done("err_recover");
  endtask

  task automatic test_mid_reset();
    int w0 = nwrites;
    do_start(2);
    queue_word(32'hCAFE_0001, 0);
    queue_word(32'hCAFE_0002, 1);
    send_bytes(6, 1'b0);
    rst = 1'b1;
    tick();
    sb.delete();
    tx_q.delete();
    check_reset_outputs("mid_reset_values");
    rst = 1'b0;
    vectors++;
    if (nwrites - w0 != 1) begin
      miscompares++;
      $display("FAIL mid_reset_writes: got %0d writes, required 1", nwrites - w0);
    end
    tick();
    do_start(1);
    queue_word(32'h0BAD_F00D, 0);
    send_bytes(4, 1'b0);
    wait_done("after_reset");
  endtask

  task automatic test_restart();
    do_start(2);
    queue_word(32'hA5A5_0000, 0);
    queue_word(32'h5A5A_FFFF, 1);
    send_bytes(2, 1'b0);
    do_start(1);
    send_bytes(6, 1'b0);
    wait_done("start_in_recv");
    do_start(1);
    vectors++;
    if ({cpu_rst, cpu_ce, done, byte_ready} !== 4'b1001) begin
      miscompares++;
      $display("FAIL start_in_done: got rst/ce/done/rdy=%b%b%b%b, required 1001",
               cpu_rst, cpu_ce, done, byte_ready);
    end
    queue_word(32'h7777_1234, 0);
    send_bytes(4, 1'b0);
    wait_done("reload");
  endtask

  task automatic test_full_depth();
    do_start(CW'(DW));
    for (int i = 0; i < DW; i++) queue_word($urandom, i);
    send_bytes(DW * 4, 1'b0);
    wait_done("full_depth");
    vectors++;
    if (mem_addr !== AW'((DW - 1) * 4)) begin
      miscompares++;
      $display("FAIL full_last_addr: got %h, required %h", mem_addr, AW'((DW - 1) * 4));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic(1'b0, "back_to_back");
    test_basic(1'b1, "toggled_valid");
    test_errors();
    test_mid_reset();
    test_restart();
    test_full_depth();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
